fpu_issue_queue: RTL and testbench

//  Request buffer sitting directly upstream of the FPU wrapper. Accepts tagged FP requests
//  (operands in IEEE format, operator, rounding mode) from the CPU and stores them in order.

---
 rtl/fpu_issue_queue.sv | 130 +++++++++++++
 tb/tb_fpu_issue_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_queue.sv
// In-order request buffer between the CPU and the FPU wrapper, with a 16-entry
// tag-busy scoreboard so a tag is never queued or in flight twice.
module fpu_issue_queue #(
  parameter int MAN_WIDTH = 53,
  parameter int EXP_WIDTH = 11,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [3:0]                     req_tag,
  input  logic [MAN_WIDTH+EXP_WIDTH-1:0] req_op1,
  input  logic [MAN_WIDTH+EXP_WIDTH-1:0] req_op2,
  input  logic [2:0]                     req_operator,
  input  logic [2:0]                     req_rm,
  input  logic                           flush,
  output logic                           fpu_in_valid,
  input  logic                           fpu_ready,
  output logic [3:0]                     fpu_tag,
  output logic [MAN_WIDTH+EXP_WIDTH-1:0] fpu_op1,
  output logic [MAN_WIDTH+EXP_WIDTH-1:0] fpu_op2,
  output logic [2:0]                     fpu_operator,
  output logic [2:0]                     fpu_rm,
  input  logic                           res_valid,
  input  logic                           res_ready,
  input  logic [3:0]                     res_tag,
  output logic [$clog2(DEPTH):0]         count,
  output logic [15:0]                    tag_busy
);

  localparam int W     = MAN_WIDTH + EXP_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 4 + 2 * W + 6;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a held valid keeps its payload stable.

  logic [ENT_W-1:0] entry_q [DEPTH];
  logic [ENT_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      busy_q, busy_d;
  logic [15:0]      flush_mask;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             push;
  logic             pop;
  logic             retire;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign req_ready    = !full && !busy_q[req_tag] && !flush;
  assign fpu_in_valid = (count_q != '0) && !flush;
  assign push         = req_valid && req_ready;
  assign pop          = fpu_in_valid && fpu_ready;
  assign retire       = res_valid && res_ready;

  assign head         = entry_q[rd_ptr_q];
  assign fpu_tag      = head[ENT_W-1 -: 4];
  assign fpu_op1      = head[ENT_W-5 -: W];
  assign fpu_op2      = head[ENT_W-5-W -: W];
  assign fpu_operator = head[5:3];
  assign fpu_rm       = head[2:0];

  assign count    = count_q;
  assign tag_busy = busy_q;

  // Tags of still-queued entries; issued tags are in flight and must stay busy on flush.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q) begin
        flush_mask[entry_q[i][ENT_W-1 -: 4]] = 1'b1;
      end
    end
  end

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;

    if (push) begin
      entry_d[wr_ptr_q] = {req_tag, req_op1, req_op2, req_operator, req_rm};
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      busy_d[req_tag]   = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (retire) begin
      busy_d[res_tag] = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      busy_d   = busy_d & ~flush_mask;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model updated on the falling edge.
module tb_fpu_issue_queue;

  localparam int MAN_WIDTH = 53;
  localparam int EXP_WIDTH = 11;
  localparam int DEPTH     = 4;
  localparam int W         = MAN_WIDTH + EXP_WIDTH;
  localparam int EW        = 4 + 2 * W + 6;

  logic         clk;
  logic         nReset;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_tag;
  logic [W-1:0] req_op1;
  logic [W-1:0] req_op2;
  logic [2:0]   req_operator;
  logic [2:0]   req_rm;
  logic         flush;
  logic         fpu_in_valid;
  logic         fpu_ready;
  logic [3:0]   fpu_tag;
  logic [W-1:0] fpu_op1;
  logic [W-1:0] fpu_op2;
  logic [2:0]   fpu_operator;
  logic [2:0]   fpu_rm;
  logic         res_valid;
  logic         res_ready;
  logic [3:0]   res_tag;
  logic [2:0]   count;
  logic [15:0]  tag_busy;

  fpu_issue_queue #(
    .MAN_WIDTH(MAN_WIDTH),
    .EXP_WIDTH(EXP_WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag(req_tag),
    .req_op1(req_op1),
    .req_op2(req_op2),
    .req_operator(req_operator),
    .req_rm(req_rm),
    .flush(flush),
    .fpu_in_valid(fpu_in_valid),
    .fpu_ready(fpu_ready),
    .fpu_tag(fpu_tag),
    .fpu_op1(fpu_op1),
    .fpu_op2(fpu_op2),
    .fpu_operator(fpu_operator),
    .fpu_rm(fpu_rm),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_tag(res_tag),
    .count(count),
    .tag_busy(tag_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int              total = 0;
  int              bad   = 0;
  logic [EW-1:0]   exp_q[$];
  logic [3:0]      infl_q[$];
  logic [15:0]     m_busy = '0;
  logic [15:0]     nxt_busy;
  logic            m_ready;
  logic            m_valid;
  logic [EW-1:0]   head_e;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nReset) begin
      m_ready = (exp_q.size() < DEPTH) && !m_busy[req_tag] && !flush;
      m_valid = (exp_q.size() != 0) && !flush;
      check("req_ready", W'(req_ready), W'(m_ready));
      check("fpu_in_valid", W'(fpu_in_valid), W'(m_valid));
      check("count", W'(count), W'(exp_q.size()));
      check("tag_busy", W'(tag_busy), W'(m_busy));
      if (m_valid && fpu_ready) begin
        head_e = exp_q.pop_front();
        check("fpu_tag", W'(fpu_tag), W'(head_e[EW-1 -: 4]));
        check("fpu_op1", fpu_op1, head_e[EW-5 -: W]);
        check("fpu_op2", fpu_op2, head_e[EW-5-W -: W]);
        check("fpu_operator", W'(fpu_operator), W'(head_e[5:3]));
        check("fpu_rm", W'(fpu_rm), W'(head_e[2:0]));
        infl_q.push_back(head_e[EW-1 -: 4]);
      end
      nxt_busy = m_busy;
      if (flush) begin
        foreach (exp_q[i]) nxt_busy[exp_q[i][EW-1 -: 4]] = 1'b0;
        exp_q.delete();
      end
      if (req_valid && m_ready) begin
        exp_q.push_back({req_tag, req_op1, req_op2, req_operator, req_rm});
        nxt_busy[req_tag] = 1'b1;
      end
      if (res_valid && res_ready) begin
        nxt_busy[res_tag] = 1'b0;
        for (int i = infl_q.size() - 1; i >= 0; i--) begin
          if (infl_q[i] == res_tag) infl_q.delete(i);
        end
      end
      m_busy = nxt_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] t);
    req_valid    = 1'b1;
    req_tag      = t;
    req_op1      = {$urandom, $urandom};
    req_op2      = {$urandom, $urandom};
    req_operator = 3'($urandom_range(0, 7));
    req_rm       = 3'($urandom_range(0, 7));
  endtask

  task automatic push_req(input logic [3:0] t);
    set_req(t);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic retire(input logic [3:0] t);
    res_valid = 1'b1;
    res_ready = 1'b1;
    res_tag   = t;
    cyc();
    res_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nReset = 1'b0;  req_valid = 1'b0; req_tag = '0; req_op1 = '0; req_op2 = '0;
    req_operator = '0; req_rm = '0; flush = 1'b0; fpu_ready = 1'b0;
    res_valid = 1'b0; res_ready = 1'b0; res_tag = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", W'(count), '0);
    check("rst_in_valid", W'(fpu_in_valid), '0);
    check("rst_tag_busy", W'(tag_busy), '0);
    nReset = 1'b1;
    #1;
    check("rst_req_ready", W'(req_ready), W'(1));

    // fill with tags 1..4 while the FPU stalls
    for (int t = 1; t <= 4; t++) begin
      set_req(4'(t));
      cyc();
    end
    req_valid = 1'b0;
    req_tag   = 4'd5;
    #1;
    check("full_count", W'(count), W'(4));
    check("full_req_ready", W'(req_ready), '0);
    check("full_tag_busy", W'(tag_busy), W'(16'h001E));

    // drain in order; tags stay busy while in flight
    fpu_ready = 1'b1;
    repeat (4) cyc();
    fpu_ready = 1'b0;
    check("drain_count", W'(count), '0);
    check("drain_tag_busy", W'(tag_busy), W'(16'h001E));
    for (int t = 1; t <= 4; t++) retire(4'(t));

    // duplicate tag blocked until its retire lands
    fpu_ready = 1'b1;
    push_req(4'd5);
    set_req(4'd5);
    #1;
    check("dup_req_ready", W'(req_ready), '0);
    cyc();
    fpu_ready = 1'b0;
    res_valid = 1'b1; res_ready = 1'b1; res_tag = 4'd5;
    #1;
    check("no_bypass_ready", W'(req_ready), '0);
    cyc();
    res_valid = 1'b0;
    #1;
    check("after_retire_ready", W'(req_ready), W'(1));
    cyc();
    req_valid = 1'b0;
    fpu_ready = 1'b1;
    cyc();
    fpu_ready = 1'b0;
    retire(4'd5);

    // full + simultaneous push/pop, then count=2 + push/pop
    for (int t = 10; t <= 13; t++) push_req(4'(t));
    set_req(4'd14);
    fpu_ready = 1'b1;
    cyc();
    check("full_pushpop_count", W'(count), W'(3));
    req_valid = 1'b0;
    cyc();
    set_req(4'd14);
    cyc();
    check("pushpop_count", W'(count), W'(2));
    req_valid = 1'b0;
    repeat (2) cyc();
    fpu_ready = 1'b0;
    for (int t = 10; t <= 14; t++) retire(4'(t));

    // flush with tag 7 in flight and 8,9 queued
    push_req(4'd7);
    fpu_ready = 1'b1;
    cyc();
    fpu_ready = 1'b0;
    push_req(4'd8);
    push_req(4'd9);
    flush = 1'b1;
    set_req(4'd3);
    fpu_ready = 1'b1;
    #1;
    check("flush_in_valid", W'(fpu_in_valid), '0);
    check("flush_req_ready", W'(req_ready), '0);
    cyc();
    flush = 1'b0; req_valid = 1'b0; fpu_ready = 1'b0;
    check("post_flush_count", W'(count), '0);
    check("post_flush_in_valid", W'(fpu_in_valid), '0);
    check("post_flush_tag_busy", W'(tag_busy), W'(16'h0080));
    retire(4'd7);

    // asynchronous reset in the middle of a burst
    fpu_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      set_req(4'(t));
      cyc();
    end
    @(posedge clk);
    #3;
    nReset = 1'b0; req_valid = 1'b0; fpu_ready = 1'b0;
    #1;
    check("async_rst_in_valid", W'(fpu_in_valid), '0);
    check("async_rst_count", W'(count), '0);
    check("async_rst_tag_busy", W'(tag_busy), '0);
    exp_q.delete();
    infl_q.delete();
    m_busy = '0;
    cyc();
    nReset = 1'b1;
    cyc();

    // random traffic
    for (int n = 0; n < 100; n++) begin
      set_req(4'($urandom_range(0, 15)));
      req_valid = 1'($urandom_range(0, 1));
      fpu_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      if (infl_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        res_valid = 1'b1;
        res_ready = 1'($urandom_range(0, 1));
        res_tag   = infl_q[$urandom_range(0, infl_q.size() - 1)];
      end else begin
        res_valid = 1'b0;
      end
      cyc();
    end
    req_valid = 1'b0; flush = 1'b0; res_valid = 1'b0; fpu_ready = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
